// File: rtl/pixel_pkg.sv
// Shared constants and FSM encoding for the UART-to-NeoPixel frame loader.
package pixel_pkg;

    localparam int         DEF_NUM_PIXELS = 10;
    localparam int         DEF_IDX_W      = 4;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

    // Byte lanes within a pixel, in wire order
    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_R    = 2'd1,
        ST_G    = 2'd2,
        ST_B    = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_frame_ram.sv
// Two-bank RGB frame store: byte-lane write port and one registered 24-bit read port.
module pixel_frame_ram
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int IDX_W      = DEF_IDX_W
) (
    input  logic             CLK,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_lane,
    input  logic [7:0]       wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [23:0]      rd_data
);

    localparam int DEPTH = 2 * NUM_PIXELS;
    localparam int AW    = IDX_W + 1;

    logic [7:0] mem_r [DEPTH];
    logic [7:0] mem_g [DEPTH];
    logic [7:0] mem_b [DEPTH];

    logic [AW-1:0] wr_a;
    logic [AW-1:0] rd_a;

    // Bank 1 occupies the upper NUM_PIXELS entries
    function automatic logic [AW-1:0] addr_of(input logic bank, input logic [IDX_W-1:0] idx);
        return (bank ? AW'(NUM_PIXELS) : '0) + AW'(idx);
    endfunction

    assign wr_a = addr_of(wr_bank, wr_idx);
    assign rd_a = ({1'b0, rd_idx} < AW'(NUM_PIXELS)) ? addr_of(rd_bank, rd_idx) : '0;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            case (wr_lane)
                COL_R:   mem_r[wr_a] <= wr_data;
                COL_G:   mem_g[wr_a] <= wr_data;
                COL_B:   mem_b[wr_a] <= wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        rd_data <= {mem_r[rd_a], mem_g[rd_a], mem_b[rd_a]};
    end

endmodule

// File: rtl/pixel_frame_loader.sv
// Parses SYNC + RGB triplets from the UART byte stream into a double-buffered
// frame store and publishes a frame to the sequencer only once it is complete.
module pixel_frame_loader
    import pixel_pkg::*;
#(
    parameter int         NUM_PIXELS     = DEF_NUM_PIXELS,
    parameter int         IDX_W          = DEF_IDX_W,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1200000,
    parameter int         TO_W           = 21
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       i_rx_byte,
    input  logic             i_rx_valid,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [7:0]       o_rd_r,
    output logic [7:0]       o_rd_g,
    output logic [7:0]       o_rd_b,
    input  logic             i_frame_done,
    output logic             o_frame_pending,
    output logic             o_frame_err,
    output logic             o_overrun
);

    state_t           state;
    state_t           state_nxt;
    logic             wr_bank;
    logic             pending;
    logic [IDX_W-1:0] pix_idx;
    logic [TO_W-1:0]  to_cnt;
    logic             rd_ok;
    logic [23:0]      ram_q;

    logic             in_frame;
    logic             last_pix;
    logic             to_expire;
    logic             start_frame;
    logic             frame_complete;
    logic             swap;
    logic             ram_we;
    logic [1:0]       ram_lane;

    assign in_frame       = (state != ST_HUNT);
    assign last_pix       = (pix_idx == IDX_W'(NUM_PIXELS - 1));
    // A byte arriving in the expiry cycle wins over the timeout
    assign to_expire      = in_frame && !i_rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign start_frame    = (state == ST_HUNT) && i_rx_valid && !pending && (i_rx_byte == SYNC_BYTE);
    assign frame_complete = (state == ST_B) && i_rx_valid && last_pix;
    assign swap           = i_frame_done && pending;

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT: if (start_frame) state_nxt = ST_R;
            ST_R: begin
                if (i_rx_valid)     state_nxt = ST_G;
                else if (to_expire) state_nxt = ST_HUNT;
            end
            ST_G: begin
                if (i_rx_valid)     state_nxt = ST_B;
                else if (to_expire) state_nxt = ST_HUNT;
            end
            ST_B: begin
                if (i_rx_valid)     state_nxt = last_pix ? ST_HUNT : ST_R;
                else if (to_expire) state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_lane = COL_R;
        case (state)
            ST_R: begin ram_we = i_rx_valid; ram_lane = COL_R; end
            ST_G: begin ram_we = i_rx_valid; ram_lane = COL_G; end
            ST_B: begin ram_we = i_rx_valid; ram_lane = COL_B; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_idx         <= '0;
            to_cnt          <= '0;
            pending         <= 1'b0;
            wr_bank         <= 1'b0;
            o_frame_err     <= 1'b0;
            o_overrun       <= 1'b0;
            rd_ok           <= 1'b0;
        end else begin
            if (start_frame)
                pix_idx <= '0;
            else if ((state == ST_B) && i_rx_valid)
                pix_idx <= pix_idx + 1'b1;

            if (!in_frame || i_rx_valid || to_expire) to_cnt <= '0;
            else                                      to_cnt <= to_cnt + 1'b1;

            // Completion and swap cannot coincide: completion implies pending was 0
            if (frame_complete) pending <= 1'b1;
            else if (swap)      pending <= 1'b0;

            if (swap) wr_bank <= ~wr_bank;

            o_frame_err <= to_expire;
            o_overrun   <= i_rx_valid && pending;
            rd_ok       <= ({1'b0, i_rd_idx} < (IDX_W + 1)'(NUM_PIXELS));
        end
    end

    assign o_frame_pending = pending;
    assign {o_rd_r, o_rd_g, o_rd_b} = rd_ok ? ram_q : 24'd0;

    pixel_frame_ram #(
        .NUM_PIXELS (NUM_PIXELS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (ram_we),
        .wr_bank (wr_bank),
        .wr_idx  (pix_idx),
        .wr_lane (ram_lane),
        .wr_data (i_rx_byte),
        .rd_bank (~wr_bank),
        .rd_idx  (i_rd_idx),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader: frame-level model plus literal checks.
module tb_pixel_frame_loader;

    localparam int         NUM_PIXELS = 10;
    localparam int         IDX_W      = 4;
    localparam int         TIMEOUT    = 300;
    localparam int         FBYTES     = 3 * NUM_PIXELS;
    localparam logic [7:0] SYNC       = 8'hA5;

    logic             clk;
    logic             RST;
    logic [7:0]       i_rx_byte;
    logic             i_rx_valid;
    logic [IDX_W-1:0] i_rd_idx;
    logic [7:0]       o_rd_r, o_rd_g, o_rd_b;
    logic             i_frame_done;
    logic             o_frame_pending;
    logic             o_frame_err;
    logic             o_overrun;

    pixel_frame_loader #(
        .NUM_PIXELS     (NUM_PIXELS),
        .IDX_W          (IDX_W),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TO_W           (9)
    ) dut (
        .CLK             (clk),
        .RST             (RST),
        .i_rx_byte       (i_rx_byte),
        .i_rx_valid      (i_rx_valid),
        .i_rd_idx        (i_rd_idx),
        .o_rd_r          (o_rd_r),
        .o_rd_g          (o_rd_g),
        .o_rd_b          (o_rd_b),
        .i_frame_done    (i_frame_done),
        .o_frame_pending (o_frame_pending),
        .o_frame_err     (o_frame_err),
        .o_overrun       (o_overrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Byte position p of a frame lands at pixel p/3, colour p%3.
    logic [7:0]  m_mem   [2][FBYTES];
    bit          m_known [2][FBYTES];
    bit          m_active = 0;
    bit          m_in_frame;
    int          m_pos;
    int          m_last_edge;
    int          edge_n = 0;
    bit          m_pending;
    bit          m_wr_bank;
    bit          e_err, e_ovr, e_rd_known;
    logic [23:0] e_rd;
    bit          m_done_frame;
    int          rb;
    int          px;

    always @(posedge clk) begin
        edge_n++;
        if (RST) begin
            m_active   = 1;
            m_in_frame = 0;
            m_pending  = 0;
            m_wr_bank  = 0;
            e_err      = 0;
            e_ovr      = 0;
            e_rd       = 24'd0;
            e_rd_known = 1;
        end else begin
            rb = m_wr_bank ? 0 : 1;
            px = int'(i_rd_idx);
            if (px < NUM_PIXELS) begin
                e_rd       = {m_mem[rb][3*px], m_mem[rb][3*px+1], m_mem[rb][3*px+2]};
                e_rd_known = m_known[rb][3*px] && m_known[rb][3*px+1] && m_known[rb][3*px+2];
            end else begin
                e_rd       = 24'd0;
                e_rd_known = 1;
            end
            e_ovr        = i_rx_valid && m_pending;
            e_err        = 0;
            m_done_frame = 0;
            if (m_in_frame) begin
                if (i_rx_valid) begin
                    m_mem[m_wr_bank][m_pos]   = i_rx_byte;
                    m_known[m_wr_bank][m_pos] = 1;
                    m_pos++;
                    m_last_edge = edge_n;
                    if (m_pos == FBYTES) begin
                        m_in_frame   = 0;
                        m_done_frame = 1;
                    end
                end else if (edge_n - m_last_edge == TIMEOUT) begin
                    m_in_frame = 0;
                    e_err      = 1;
                end
            end else if (i_rx_valid && !m_pending && i_rx_byte == SYNC) begin
                m_in_frame  = 1;
                m_pos       = 0;
                m_last_edge = edge_n;
            end
            if (i_frame_done && m_pending) begin
                m_wr_bank = !m_wr_bank;
                m_pending = 0;
            end
            if (m_done_frame) m_pending = 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_active) begin
            chk("pending", 24'(o_frame_pending), 24'(m_pending));
            chk("frame_err", 24'(o_frame_err), 24'(e_err));
            chk("overrun", 24'(o_overrun), 24'(e_ovr));
            if (e_rd_known) chk("rd_rgb", {o_rd_r, o_rd_g, o_rd_b}, e_rd);
            err_cnt += int'(o_frame_err);
            ovr_cnt += int'(o_overrun);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_byte  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    // SYNC followed by bytes base+1 .. base+nbytes
    task automatic send_frame(input logic [7:0] base, input int nbytes);
        send_byte(SYNC);
        for (int k = 1; k <= nbytes; k++) send_byte(base + 8'(k));
    endtask

    task automatic pulse_done();
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
    endtask

    task automatic read_px(input int idx, output logic [23:0] rgb);
        i_rd_idx = IDX_W'(idx);
        tick();
        rgb = {o_rd_r, o_rd_g, o_rd_b};
    endtask

    // ---------------- stimulus ----------------
    logic [23:0] rgb;
    int          base_cnt;

    initial begin
        RST          = 1'b1;
        i_rx_byte    = 8'h00;
        i_rx_valid   = 1'b0;
        i_rd_idx     = 4'd15;
        i_frame_done = 1'b0;
        repeat (3) tick();
        chk("rst_pending", 24'(o_frame_pending), 24'd0);
        chk("rst_err_ovr", {22'd0, o_frame_err, o_overrun}, 24'd0);
        chk("rst_rd", {o_rd_r, o_rd_g, o_rd_b}, 24'd0);
        RST = 1'b0;
        tick();

        // 1: basic frame load and publish
        send_frame(8'h00, FBYTES);
        chk("s1_pending_up", 24'(o_frame_pending), 24'd1);
        pulse_done();
        chk("s1_pending_down", 24'(o_frame_pending), 24'd0);
        read_px(0, rgb); chk("s1_px0", rgb, 24'h010203);
        read_px(9, rgb); chk("s1_px9", rgb, 24'h1C1D1E);

        // 2: garbage before sync is ignored
        base_cnt = err_cnt;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hFF);
        send_frame(8'h00, FBYTES);
        pulse_done();
        tick();
        chk("s2_no_err", 24'(err_cnt - base_cnt), 24'd0);
        read_px(0, rgb); chk("s2_px0", rgb, 24'h010203);
        read_px(9, rgb); chk("s2_px9", rgb, 24'h1C1D1E);

        // 3: inter-byte timeout drops the partial frame
        base_cnt = err_cnt;
        send_frame(8'h50, 5);
        repeat (TIMEOUT + 5) tick();
        chk("s3_err_once", 24'(err_cnt - base_cnt), 24'd1);
        chk("s3_pending", 24'(o_frame_pending), 24'd0);
        read_px(0, rgb); chk("s3_readbank_kept", rgb, 24'h010203);
        send_frame(8'h40, FBYTES);
        pulse_done();
        read_px(0, rgb); chk("s3_px0_new", rgb, 24'h414243);

        // 4: bytes dropped while a frame is pending
        send_frame(8'h60, FBYTES);
        base_cnt = ovr_cnt;
        send_frame(8'hA0, FBYTES);
        tick(); tick();
        chk("s4_overruns", 24'(ovr_cnt - base_cnt), 24'd31);
        pulse_done();
        read_px(0, rgb); chk("s4_px0", rgb, 24'h616263);
        read_px(9, rgb); chk("s4_px9", rgb, 24'h7C7D7E);

        // 5: out-of-range reads and read in the swap cycle
        for (int i = 10; i < 16; i++) begin
            read_px(i, rgb);
            chk($sformatf("s5_oor_%0d", i), rgb, 24'h000000);
        end
        send_frame(8'h20, FBYTES);
        i_rd_idx     = 4'd0;
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
        chk("s5_swap_old", {o_rd_r, o_rd_g, o_rd_b}, 24'h616263);
        tick();
        chk("s5_swap_new", {o_rd_r, o_rd_g, o_rd_b}, 24'h212223);

        // 6: reset in the middle of a frame
        send_frame(8'h90, 16);
        RST = 1'b1;
        tick();
        chk("s6_rst_pending", 24'(o_frame_pending), 24'd0);
        chk("s6_rst_rd", {o_rd_r, o_rd_g, o_rd_b}, 24'd0);
        chk("s6_rst_err_ovr", {22'd0, o_frame_err, o_overrun}, 24'd0);
        RST = 1'b0;
        send_frame(8'hC0, FBYTES);
        chk("s6_pending_up", 24'(o_frame_pending), 24'd1);
        pulse_done();
        read_px(0, rgb); chk("s6_px0", rgb, 24'hC1C2C3);
        read_px(5, rgb); chk("s6_px5", rgb, 24'hD0D1D2);
        i_rd_idx = 4'd15;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
